mem_reader: RTL

Read-side streaming engine for the dual-port RAM primitive. Accepts a command (start address, word count), issues read strobes to the RAM read port, absorbs the RAM's one-cycle read latency, and presents the words as a valid/ready stream with backpressure and a last-word flag. Sits between a frame buffer RAM and the transmit path of the FT245 bridge.

---
 rtl/mem_reader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_reader.sv
// rtl/mem_reader.sv - streams words from the RAM read port as a valid/ready stream
// Read strobes are registered; a 3-entry FIFO absorbs the one-cycle RAM read latency.
module mem_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [LEN_W-1:0]  issue_rem;
  logic [LEN_W-1:0]  out_rem;
  logic              rd_q;
  logic [DATA_W-1:0] fifo0, fifo1, fifo2;
  logic [1:0]        wr_ptr, rd_ptr, count;
  logic              push, pop;
  logic [2:0]        count_n;
  logic              can_issue;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (count != 2'd0);
  assign out_last  = out_valid && (out_rem == LEN_W'(1));
  assign push      = rd_q;
  assign pop       = out_valid && out_ready;

  // A read issued next cycle lands two edges later, so it must fit beside the
  // post-edge occupancy plus the read currently on the RAM port.
  always_comb begin
    count_n   = {1'b0, count} + {2'b0, push} - {2'b0, pop};
    can_issue = (issue_rem != '0) && ((count_n + {2'b0, mem_rd}) < 3'd3);
  end

  always_comb begin
    case (rd_ptr)
      2'd0:    out_data = fifo0;
      2'd1:    out_data = fifo1;
      default: out_data = fifo2;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo0  <= '0;
      fifo1  <= '0;
      fifo2  <= '0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        case (wr_ptr)
          2'd0:    fifo0 <= mem_rdata;
          2'd1:    fifo1 <= mem_rdata;
          default: fifo2 <= mem_rdata;
        endcase
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count_n[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      issue_rem <= '0;
      out_rem   <= '0;
      mem_rd    <= 1'b0;
      mem_raddr <= '0;
      rd_q      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      rd_q <= mem_rd;
      if (pop) out_rem <= out_rem - 1'b1;
      case (state)
        IDLE: begin
          mem_rd <= 1'b0;
          if (cmd_valid) begin
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else begin
              mem_rd    <= 1'b1;
              mem_raddr <= cmd_addr;
              addr_cnt  <= cmd_addr + 1'b1;
              issue_rem <= cmd_len - 1'b1;
              out_rem   <= cmd_len;
              state     <= (cmd_len == LEN_W'(1)) ? DRAIN : READ;
            end
          end
        end
        READ: begin
          if (can_issue) begin
            mem_rd    <= 1'b1;
            mem_raddr <= addr_cnt;
            addr_cnt  <= addr_cnt + 1'b1;
            issue_rem <= issue_rem - 1'b1;
            if (issue_rem == LEN_W'(1)) state <= DRAIN;
          end else begin
            mem_rd <= 1'b0;
          end
        end
        DRAIN: begin
          mem_rd <= 1'b0;
          if (pop && out_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          mem_rd <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
